// File: rtl/std_cache_pkg.sv
// Shared cache-subsystem definitions.
// Write-scheduler FSM encoding and the fixed requester slots on the shared
// AXI write port.
package std_cache_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } wr_sched_state_e;

  localparam int unsigned WR_PORT_ICACHE = 0;
  localparam int unsigned WR_PORT_BYPASS = 1;
  localparam int unsigned WR_PORT_DCACHE = 2;

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO without fall-through.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   flush_i        synchronous empty
//   push_i/data_i  write side (push ignored when full)
//   pop_i/data_o   read side, data_o is the head entry (pop ignored when empty)
//   full_o/empty_o occupancy flags
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]        cnt_q;
  logic                  do_push, do_pop;

  assign full_o  = (cnt_q == DepthCnt);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + (AddrW + 1)'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - (AddrW + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/cache_axi_wr_scheduler.sv
// Write-path scheduler for the cache subsystem's shared AXI master port.
// Round-robin AW arbitration between I$ (0), bypass (1) and D$ (2), in-order
// W steering through a grant-order FIFO, and per-port outstanding-write credit
// tracking until B. Only selects/handshakes are produced here.
// Ports:
//   clk_i, rst_ni, clr_i       clock, async active-low reset, sync clear
//   stall_i                    blocks new AW grants (a locked grant completes)
//   inp_aw_valid_i/ready_o     per-port AW handshake
//   oup_aw_valid_o/ready_i     AXI AW handshake, aw_sel_o drives payload mux
//   inp_w_valid_i/last_i/ready_o  per-port W handshake
//   oup_w_valid_o/ready_i      AXI W handshake, w_sel_o drives payload mux
//   b_valid_i, b_port_i        completed B handshake and its decoded port
//   busy_o                     outstanding writes or pending W bursts
//   err_o                      one-cycle pulse on B for a port with no credit used
//
// state | meaning
// ARB   | winner picked combinationally from eligible ports
// LOCK  | AW shown without ready; hold the presented port until handshake
module cache_axi_wr_scheduler
  import std_cache_pkg::*;
#(
  parameter int unsigned NumPorts       = 3,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned WFifoDepth     = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clr_i,
  input  logic                        stall_i,
  input  logic [NumPorts-1:0]         inp_aw_valid_i,
  output logic [NumPorts-1:0]         inp_aw_ready_o,
  output logic                        oup_aw_valid_o,
  input  logic                        oup_aw_ready_i,
  output logic [$clog2(NumPorts)-1:0] aw_sel_o,
  input  logic [NumPorts-1:0]         inp_w_valid_i,
  input  logic [NumPorts-1:0]         inp_w_last_i,
  output logic [NumPorts-1:0]         inp_w_ready_o,
  output logic                        oup_w_valid_o,
  input  logic                        oup_w_ready_i,
  output logic [$clog2(NumPorts)-1:0] w_sel_o,
  input  logic                        b_valid_i,
  input  logic [$clog2(NumPorts)-1:0] b_port_i,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam int unsigned SelW = $clog2(NumPorts);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt   = CntW'(MaxOutstanding);
  localparam logic [SelW-1:0] LastPort = SelW'(NumPorts - 1);

  function automatic logic [SelW-1:0] rr_pick(input logic [NumPorts-1:0] req,
                                              input logic [SelW-1:0]     ptr);
    logic [SelW-1:0] pick;
    logic            found;
    int unsigned     idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      idx = (int'(ptr) + k) % NumPorts;
      if (!found && req[idx]) begin
        pick  = SelW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Bit select that never indexes past NumPorts for unused select codes.
  function automatic logic sel_bit(input logic [NumPorts-1:0] vec,
                                   input logic [SelW-1:0]     idx);
    logic b;
    b = 1'b0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (idx == SelW'(i)) b = vec[i];
    end
    return b;
  endfunction

  wr_sched_state_e state_q;
  logic [SelW-1:0] lock_sel_q, rr_ptr_q;
  logic [CntW-1:0] cnt_q [NumPorts];
  logic            err_q;

  logic                active;
  logic [NumPorts-1:0] elig;
  logic [SelW-1:0]     aw_sel;
  logic                aw_valid, aw_hs;
  logic                fifo_full, fifo_empty, fifo_pop;
  logic [SelW-1:0]     w_head;
  logic                w_valid;
  logic [NumPorts-1:0] cnt_inc, cnt_dec;
  logic                b_err, cnt_busy;

  // Reset and clear both force every output low, including the
  // combinational handshake paths.
  assign active = rst_ni && !clr_i;

  always_comb begin
    elig     = '0;
    aw_sel   = '0;
    aw_valid = 1'b0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      elig[i] = inp_aw_valid_i[i] && (cnt_q[i] < MaxCnt) && !fifo_full && !stall_i;
    end
    if (state_q == LOCK) begin
      aw_sel   = lock_sel_q;
      aw_valid = sel_bit(inp_aw_valid_i, lock_sel_q);
    end else begin
      aw_sel   = rr_pick(elig, rr_ptr_q);
      aw_valid = |elig;
    end
    aw_valid = aw_valid && active;
  end

  assign aw_hs          = aw_valid && oup_aw_ready_i;
  assign oup_aw_valid_o = aw_valid;
  assign aw_sel_o       = active ? aw_sel : '0;

  always_comb begin
    inp_aw_ready_o = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      inp_aw_ready_o[i] = aw_valid && (aw_sel == SelW'(i)) && oup_aw_ready_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB;
      lock_sel_q <= '0;
      rr_ptr_q   <= '0;
    end else if (clr_i) begin
      state_q    <= ARB;
      lock_sel_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      case (state_q)
        ARB: begin
          if (aw_valid && !oup_aw_ready_i) begin
            state_q    <= LOCK;
            lock_sel_q <= aw_sel;
          end
        end
        LOCK: begin
          if (aw_hs) state_q <= ARB;
        end
        default: state_q <= ARB;
      endcase
      if (aw_hs) rr_ptr_q <= (aw_sel == LastPort) ? '0 : aw_sel + SelW'(1);
    end
  end

  // Grant order; W bursts are steered strictly in AW acceptance order.
  fifo_v3 #(
    .DATA_WIDTH (SelW),
    .DEPTH      (WFifoDepth)
  ) i_w_order_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clr_i),
    .push_i  (aw_hs),
    .data_i  (aw_sel),
    .pop_i   (fifo_pop),
    .data_o  (w_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign w_valid       = active && !fifo_empty && sel_bit(inp_w_valid_i, w_head);
  assign oup_w_valid_o = w_valid;
  assign w_sel_o       = (active && !fifo_empty) ? w_head : '0;
  assign fifo_pop      = w_valid && oup_w_ready_i && sel_bit(inp_w_last_i, w_head);

  always_comb begin
    inp_w_ready_o = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      inp_w_ready_o[i] = active && !fifo_empty && (w_head == SelW'(i)) && oup_w_ready_i;
    end
  end

  always_comb begin
    cnt_inc  = '0;
    cnt_dec  = '0;
    b_err    = 1'b0;
    cnt_busy = 1'b0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      cnt_inc[i] = aw_hs && (aw_sel == SelW'(i));
      cnt_dec[i] = b_valid_i && (b_port_i == SelW'(i));
      if (cnt_dec[i] && (cnt_q[i] == '0)) b_err = 1'b1;
      if (cnt_q[i] != '0) cnt_busy = 1'b1;
    end
  end

  // No wrap guard on increment: eligibility stops grants at MaxOutstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
      for (int unsigned i = 0; i < NumPorts; i++) cnt_q[i] <= '0;
    end else if (clr_i) begin
      err_q <= 1'b0;
      for (int unsigned i = 0; i < NumPorts; i++) cnt_q[i] <= '0;
    end else begin
      err_q <= b_err;
      for (int unsigned i = 0; i < NumPorts; i++) begin
        if (cnt_inc[i] && !cnt_dec[i]) begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end else if (cnt_dec[i] && !cnt_inc[i] && (cnt_q[i] != '0)) begin
          cnt_q[i] <= cnt_q[i] - CntW'(1);
        end
      end
    end
  end

  assign err_o  = err_q && active;
  assign busy_o = active && (cnt_busy || !fifo_empty);

endmodule

// File: tb/tb_cache_axi_wr_scheduler.sv
module tb_cache_axi_wr_scheduler;
  import std_cache_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_ni, clr_i, stall_i;
  logic [2:0] aw_v, aw_r, w_v, w_last, w_r;
  logic       oup_aw_valid, oup_aw_ready, oup_w_valid, oup_w_ready;
  logic [1:0] aw_sel, w_sel, b_port;
  logic       b_valid, busy, err;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] P_BYP = 2'(WR_PORT_BYPASS);
  localparam logic [1:0] P_DC  = 2'(WR_PORT_DCACHE);

  cache_axi_wr_scheduler #(
    .NumPorts(3), .MaxOutstanding(4), .WFifoDepth(4)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clr_i          (clr_i),
    .stall_i        (stall_i),
    .inp_aw_valid_i (aw_v),
    .inp_aw_ready_o (aw_r),
    .oup_aw_valid_o (oup_aw_valid),
    .oup_aw_ready_i (oup_aw_ready),
    .aw_sel_o       (aw_sel),
    .inp_w_valid_i  (w_v),
    .inp_w_last_i   (w_last),
    .inp_w_ready_o  (w_r),
    .oup_w_valid_o  (oup_w_valid),
    .oup_w_ready_i  (oup_w_ready),
    .w_sel_o        (w_sel),
    .b_valid_i      (b_valid),
    .b_port_i       (b_port),
    .busy_o         (busy),
    .err_o          (err)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs;
    clr_i = 0; stall_i = 0; aw_v = 0; w_v = 0; w_last = 0;
    oup_aw_ready = 0; oup_w_ready = 0; b_valid = 0; b_port = 0;
  endtask

  task automatic apply_reset;
    idle_inputs();
    rst_ni = 0;
    tick();
    tick();
    rst_ni = 1;
  endtask

  task automatic test_reset;
    rst_ni = 0;
    idle_inputs();
    aw_v = 3'b111; w_v = 3'b111; w_last = 3'b111;
    oup_aw_ready = 1; oup_w_ready = 1; b_valid = 1;
    #1;
    checks++;
    if ({oup_aw_valid, aw_r, aw_sel} !== 6'b0) begin
      errors++; $display("FAIL reset_aw got=%b exp=0", {oup_aw_valid, aw_r, aw_sel});
    end
    checks++;
    if ({oup_w_valid, w_r, w_sel, busy, err} !== 8'b0) begin
      errors++; $display("FAIL reset_w got=%b exp=0", {oup_w_valid, w_r, w_sel, busy, err});
    end
    tick();
    checks++;
    if ({dut.cnt_q[0], dut.cnt_q[1], dut.cnt_q[2]} !== 9'b0) begin
      errors++; $display("FAIL reset_cnt got=%b exp=0", {dut.cnt_q[0], dut.cnt_q[1], dut.cnt_q[2]});
    end
  endtask

  task automatic test_round_robin;
    apply_reset();
    aw_v = 3'b110; oup_aw_ready = 1;
    #1;
    checks++;
    if ({oup_aw_valid, aw_sel, aw_r} !== {1'b1, P_BYP, 3'b010}) begin
      errors++; $display("FAIL rr_cycle0 got=%b exp=%b", {oup_aw_valid, aw_sel, aw_r}, {1'b1, P_BYP, 3'b010});
    end
    tick();
    aw_v = 3'b100;
    #1;
    checks++;
    if ({oup_aw_valid, aw_sel, aw_r} !== {1'b1, P_DC, 3'b100}) begin
      errors++; $display("FAIL rr_cycle1 got=%b exp=%b", {oup_aw_valid, aw_sel, aw_r}, {1'b1, P_DC, 3'b100});
    end
    tick();
    aw_v = 0;
    #1;
    checks++;
    if ({dut.cnt_q[0], dut.cnt_q[1], dut.cnt_q[2]} !== {3'd0, 3'd1, 3'd1}) begin
      errors++; $display("FAIL rr_cnt got=%b exp=%b", {dut.cnt_q[0], dut.cnt_q[1], dut.cnt_q[2]}, {3'd0, 3'd1, 3'd1});
    end
    checks++;
    if ({busy, oup_aw_valid, aw_sel} !== 4'b1000) begin
      errors++; $display("FAIL rr_busy got=%b exp=1000", {busy, oup_aw_valid, aw_sel});
    end
  endtask

  task automatic test_lock;
    apply_reset();
    aw_v = 3'b100; oup_aw_ready = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) aw_v = 3'b110;
      if (c == 2) stall_i = 1;
      #1;
      checks++;
      if ({oup_aw_valid, aw_sel, aw_r} !== {1'b1, P_DC, 3'b000}) begin
        errors++; $display("FAIL lock_hold c=%0d got=%b exp=%b", c, {oup_aw_valid, aw_sel, aw_r}, {1'b1, P_DC, 3'b000});
      end
      tick();
    end
    stall_i = 0; oup_aw_ready = 1;
    #1;
    checks++;
    if ({oup_aw_valid, aw_sel, aw_r} !== {1'b1, P_DC, 3'b100}) begin
      errors++; $display("FAIL lock_handshake got=%b exp=%b", {oup_aw_valid, aw_sel, aw_r}, {1'b1, P_DC, 3'b100});
    end
    tick();
    aw_v = 3'b010;
    #1;
    checks++;
    if ({oup_aw_valid, aw_sel, aw_r} !== {1'b1, P_BYP, 3'b010}) begin
      errors++; $display("FAIL lock_next got=%b exp=%b", {oup_aw_valid, aw_sel, aw_r}, {1'b1, P_BYP, 3'b010});
    end
    tick();
    aw_v = 0;
  endtask

  task automatic test_w_order;
    apply_reset();
    oup_aw_ready = 1; aw_v = 3'b100;
    tick();
    aw_v = 3'b010;
    #1;
    checks++;
    if ({w_sel, oup_w_valid, w_r} !== {P_DC, 1'b0, 3'b000}) begin
      errors++; $display("FAIL w_wait got=%b exp=%b", {w_sel, oup_w_valid, w_r}, {P_DC, 1'b0, 3'b000});
    end
    tick();
    aw_v = 0; w_v = 3'b110; oup_w_ready = 1;
    for (int b = 0; b < 4; b++) begin
      w_last = (b == 3) ? 3'b110 : 3'b010;
      #1;
      checks++;
      if ({w_sel, oup_w_valid, w_r} !== {P_DC, 1'b1, 3'b100}) begin
        errors++; $display("FAIL w_dcache beat=%0d got=%b exp=%b", b, {w_sel, oup_w_valid, w_r}, {P_DC, 1'b1, 3'b100});
      end
      tick();
    end
    w_last = 3'b010;
    #1;
    checks++;
    if ({w_sel, oup_w_valid, w_r} !== {P_BYP, 1'b1, 3'b010}) begin
      errors++; $display("FAIL w_bypass got=%b exp=%b", {w_sel, oup_w_valid, w_r}, {P_BYP, 1'b1, 3'b010});
    end
    tick();
    #1;
    checks++;
    if ({w_sel, oup_w_valid, w_r, busy} !== 7'b0000001) begin
      errors++; $display("FAIL w_empty got=%b exp=0000001", {w_sel, oup_w_valid, w_r, busy});
    end
    idle_inputs();
  endtask

  task automatic test_credit;
    apply_reset();
    oup_aw_ready = 1; aw_v = 3'b100;
    w_v = 3'b100; w_last = 3'b100; oup_w_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (aw_r !== 3'b100) begin
        errors++; $display("FAIL credit_grant k=%0d got=%b exp=100", k, aw_r);
      end
      tick();
    end
    b_valid = 1; b_port = P_DC;
    #1;
    checks++;
    if ({oup_aw_valid, aw_r} !== 4'b0000) begin
      errors++; $display("FAIL credit_block got=%b exp=0000", {oup_aw_valid, aw_r});
    end
    tick();
    b_valid = 0;
    #1;
    checks++;
    if ({oup_aw_valid, aw_r, err} !== 5'b11000) begin
      errors++; $display("FAIL credit_release got=%b exp=11000", {oup_aw_valid, aw_r, err});
    end
    tick();
    aw_v = 0;
    #1;
    checks++;
    if (dut.cnt_q[2] !== 3'd4) begin
      errors++; $display("FAIL credit_cnt got=%0d exp=4", dut.cnt_q[2]);
    end
    idle_inputs();
  endtask

  task automatic test_fifo_full;
    logic [2:0] seq [4];
    seq[0] = 3'b010; seq[1] = 3'b100; seq[2] = 3'b010; seq[3] = 3'b100;
    apply_reset();
    oup_aw_ready = 1;
    for (int k = 0; k < 4; k++) begin
      aw_v = seq[k];
      tick();
    end
    aw_v = 3'b001; w_v = 3'b010; w_last = 3'b010; oup_w_ready = 1;
    #1;
    checks++;
    if ({oup_aw_valid, aw_r, w_sel, w_r} !== {1'b0, 3'b000, P_BYP, 3'b010}) begin
      errors++; $display("FAIL full_block got=%b exp=%b", {oup_aw_valid, aw_r, w_sel, w_r}, {1'b0, 3'b000, P_BYP, 3'b010});
    end
    tick();
    w_v = 0;
    #1;
    checks++;
    if ({oup_aw_valid, aw_sel, aw_r} !== {1'b1, 2'd0, 3'b001}) begin
      errors++; $display("FAIL full_release got=%b exp=%b", {oup_aw_valid, aw_sel, aw_r}, {1'b1, 2'd0, 3'b001});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_err;
    apply_reset();
    b_valid = 1; b_port = P_BYP;
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_before got=%b exp=0", err);
    end
    tick();
    b_valid = 0;
    #1;
    checks++;
    if ({err, dut.cnt_q[1]} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL err_pulse got=%b exp=%b", {err, dut.cnt_q[1]}, {1'b1, 3'd0});
    end
    tick();
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_after got=%b exp=0", err);
    end
  endtask

  task automatic test_stall;
    apply_reset();
    stall_i = 1; aw_v = 3'b010; oup_aw_ready = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({oup_aw_valid, aw_r} !== 4'b0000) begin
        errors++; $display("FAIL stall_hold c=%0d got=%b exp=0000", c, {oup_aw_valid, aw_r});
      end
      tick();
    end
    checks++;
    if ({dut.cnt_q[1], busy} !== 4'b0000) begin
      errors++; $display("FAIL stall_cnt got=%b exp=0000", {dut.cnt_q[1], busy});
    end
    stall_i = 0;
    #1;
    checks++;
    if ({oup_aw_valid, aw_r} !== 4'b1010) begin
      errors++; $display("FAIL stall_release got=%b exp=1010", {oup_aw_valid, aw_r});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid;
    apply_reset();
    oup_aw_ready = 1; aw_v = 3'b100;
    tick();
    aw_v = 0; w_v = 3'b100; w_last = 0; oup_w_ready = 1;
    tick();
    #1;
    checks++;
    if ({busy, oup_w_valid} !== 2'b11) begin
      errors++; $display("FAIL mid_busy got=%b exp=11", {busy, oup_w_valid});
    end
    aw_v = 3'b110; oup_aw_ready = 1;
    #2;
    rst_ni = 0;
    #1;
    checks++;
    if ({oup_aw_valid, aw_r, aw_sel, oup_w_valid, w_r, w_sel, busy, err} !== 14'b0) begin
      errors++; $display("FAIL mid_reset_out got=%b exp=0", {oup_aw_valid, aw_r, aw_sel, oup_w_valid, w_r, w_sel, busy, err});
    end
    checks++;
    if ({dut.cnt_q[0], dut.cnt_q[1], dut.cnt_q[2]} !== 9'b0) begin
      errors++; $display("FAIL mid_reset_cnt got=%b exp=0", {dut.cnt_q[0], dut.cnt_q[1], dut.cnt_q[2]});
    end
    idle_inputs();
  endtask

  task automatic test_clr;
    apply_reset();
    oup_aw_ready = 1; aw_v = 3'b100;
    tick();
    aw_v = 0; clr_i = 1;
    #1;
    checks++;
    if ({busy, w_sel} !== 3'b000) begin
      errors++; $display("FAIL clr_during got=%b exp=000", {busy, w_sel});
    end
    tick();
    clr_i = 0; w_v = 3'b100; oup_w_ready = 1;
    #1;
    checks++;
    if ({busy, oup_w_valid, w_r, dut.cnt_q[2]} !== 8'b0) begin
      errors++; $display("FAIL clr_after got=%b exp=0", {busy, oup_w_valid, w_r, dut.cnt_q[2]});
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_w_order();
    test_credit();
    test_fifo_full();
    test_err();
    test_stall();
    test_reset_mid();
    test_clr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
